demux64x1_4_buf: RTL and testbench
==================================

Name: demux64x1_4_buf

Overview:
- 64-bit, 1-to-4 routing demultiplexer with per-destination buffering. It is the write/distribute counterpart of the 64-bit 4:1 select path.
- Takes one 64-bit word plus a 2-bit destination per transfer, and queues the word in a small FIFO for the selected destination.
- Each of the four destinations drains independently through its own valid/ready handshake.
- Used to fan results (ALU/memory/forwarding) out to four consumers that stall independently.

Parameters:
- WIDTH, 64, data width of every channel.
- DEPTH, 2, entries per destination FIFO; power of 2, minimum 2.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  producer offers a word
- in_ready  output  1  block accepts the word this cycle
- in_data  input  WIDTH  word to route
- in_select  input  2  destination index 0..3
- out_valid  output  4  bit i: destination i FIFO non-empty
- out_ready  input  4  bit i: consumer i takes the head this cycle
- out_data_0..out_data_3  output  WIDTH each  head entry of destination FIFO 0..3
- occupancy  output  4*($clog2(DEPTH)+1)  packed per-channel entry counts; channel i at [i*(C)+:C], where C = $clog2(DEPTH)+1
- overflow_sticky  output  1  set if in_valid is held with in_select changing while in_ready is low (protocol violation); cleared only by reset

Behaviour:
- Reset (reset_n low, asynchronous):
  - All FIFOs empty, all pointers 0, occupancy 0.
  - out_valid = 4'b0000, overflow_sticky = 0.
  - out_data_* = 0. Storage is not required to reset; the head mux is forced to 0 when its FIFO is empty.
- Reset release: in_ready reflects the empty state immediately (combinational from state).
- Push:
  - Occurs on a rising edge when in_valid & in_ready.
  - in_data is written to FIFO[in_select] and occupancy[in_select] increments.
  - Other FIFOs are untouched.
- in_ready = !full[in_select]. It is combinational on in_select.
- No pop-bypass: a full FIFO keeps in_ready low even if it is popped in the same cycle. The slot frees on the next cycle.
- Pop on channel i:
  - Occurs on a rising edge when out_valid[i] & out_ready[i].
  - The head pointer advances and the next entry appears on out_data_i after that edge.
- Latency: a word pushed at edge k is visible on out_valid/out_data of its destination in the cycle following edge k. There is no combinational path from in_data to out_data.
- Ordering: per-destination FIFO order is preserved. There is no ordering guarantee between destinations.
- Simultaneous push and pop on the same channel:
  - Allowed when not full: occupancy is unchanged, the head advances, and the tail write lands correctly.
  - With occupancy 1, the pushed word becomes the new head next cycle.
- Simultaneous pops on several channels in one cycle are all honoured.
- out_ready[i] while out_valid[i] = 0 is ignored and occupancy does not underflow.
- in_valid while in_ready = 0: no write, no state change. The producer must hold in_data and in_select stable.
  - A change of in_select while stalled sets overflow_sticky. The new select is still evaluated normally on the next cycle.
- Pointer wrap: read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. full/empty are derived from occupancy.
  - full = (occupancy == DEPTH)
  - empty = (occupancy == 0)
- Reset asserted mid-operation: all queued words are discarded immediately and outputs return to reset values asynchronously. No partial push or pop completes.
- in_select X while in_valid = 0 must not corrupt state. in_ready is don't-care in that case.

Test Plan:
- Reset/basic:
  - Assert reset_n = 0, then release.
  - Push 64'h5555555555555555 to sel 0.
  - -> out_valid = 4'b0001 one cycle later, out_data_0 = 64'h5555555555555555, occupancy ch0 = 1.
  - Pop with out_ready[0] = 1 -> out_valid = 0, out_data_0 = 0.
- Routing:
  - Push 64'h3333333333333333 to sel 1, 64'h0F0F0F0F0F0F0F0F to sel 2, and 64'h00FF00FF00FF00FF to sel 3 on consecutive cycles, with out_ready = 0.
  - -> out_valid = 4'b1110 and each out_data_i matches its word; channel 0 stays empty.
- Full/backpressure:
  - With out_ready[2] = 0, push 3 words to sel 2.
  - -> first 2 accepted, in_ready = 0 on the third, occupancy ch2 = 2.
  - Raise out_ready[2] for one cycle -> in_ready stays 0 that cycle (no bypass) and returns to 1 the next cycle.
  - Third word accepted; order is 1, 2, 3 on out_data_2.
- Push+pop same channel:
  - Occupancy ch3 = 1; push 64'hA and pop in the same cycle.
  - -> occupancy stays 1, out_data_3 = 64'hA next cycle.
- Wrap:
  - Stream 10 words (values 1..10) through sel 0 with out_ready[0] = 1 continuously.
  - -> all 10 appear in order, each one cycle after acceptance, and pointers wrap cleanly.
- Mid-operation reset and protocol check:
  - Fill ch1 to full, then stall a push to sel 1 and change in_select to 0 while stalled -> overflow_sticky = 1.
  - Pulse reset_n low between clock edges -> occupancy and out_valid go to 0 immediately, and overflow_sticky = 0.

Source files
------------

// File: rtl/demux64x1_4_buf.sv
// 1-to-4 routing demultiplexer: each accepted word is queued in a small FIFO
// for its destination, and each destination drains through its own valid/ready.
module demux64x1_4_buf #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  in_data,
    input  logic [1:0]                        in_select,
    output logic [3:0]                        out_valid,
    input  logic [3:0]                        out_ready,
    output logic [WIDTH-1:0]                  out_data_0,
    output logic [WIDTH-1:0]                  out_data_1,
    output logic [WIDTH-1:0]                  out_data_2,
    output logic [WIDTH-1:0]                  out_data_3,
    output logic [4*($clog2(DEPTH)+1)-1:0]    occupancy,
    output logic                              overflow_sticky
);

    localparam int NUM_CH = 4;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [WIDTH-1:0]  head [NUM_CH];
    logic              accept;

    logic              stall_q;
    logic [1:0]        sel_q;

    // NOTE: full comes from the registered count only, so a pop in the same
    // cycle cannot reopen in_ready; the freed slot is visible one cycle later.
    assign in_ready = ~full[in_select];
    assign accept   = in_valid & in_ready;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [WIDTH-1:0] mem [DEPTH];
        logic [PTR_W-1:0] rd_ptr;
        logic [PTR_W-1:0] wr_ptr;
        logic [CNT_W-1:0] count;

        assign full[ch]  = (count == CNT_W'(DEPTH));
        assign empty[ch] = (count == '0);
        assign push[ch]  = accept && (in_select == 2'(ch));
        assign pop[ch]   = ~empty[ch] & out_ready[ch];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[ch]) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop[ch])  rd_ptr <= rd_ptr + PTR_W'(1);
                case ({push[ch], pop[ch]})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end

        // NOTE: storage has no reset; the head mux below hides stale entries
        // whenever the FIFO is empty, so a reset on the array buys nothing.
        always_ff @(posedge clk) begin
            if (push[ch]) mem[wr_ptr] <= in_data;
        end

        assign head[ch]      = empty[ch] ? '0 : mem[rd_ptr];
        assign out_valid[ch] = ~empty[ch];
        assign occupancy[ch*CNT_W +: CNT_W] = count;
    end

    assign out_data_0 = head[0];
    assign out_data_1 = head[1];
    assign out_data_2 = head[2];
    assign out_data_3 = head[3];

    // A stalled producer must hold its destination; a changed select while
    // the previous cycle was stalled is latched as a protocol violation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q         <= 1'b0;
            sel_q           <= 2'b00;
            overflow_sticky <= 1'b0;
        end else begin
            stall_q <= in_valid & ~in_ready;
            sel_q   <= in_select;
            if (stall_q && in_valid && (in_select != sel_q))
                overflow_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_demux64x1_4_buf.sv
// Scoreboard bench for demux64x1_4_buf: a driver queues expected words per
// destination; a negedge monitor compares every destination head against them.
module tb_demux64x1_4_buf;

    localparam int WIDTH = 64;
    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data = '0;
    logic [1:0]        in_select = 2'b00;
    logic [3:0]        out_valid;
    logic [3:0]        out_ready = 4'b0000;
    logic [WIDTH-1:0]  out_data_0, out_data_1, out_data_2, out_data_3;
    logic [4*CNT_W-1:0] occupancy;
    logic              overflow_sticky;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: one queue of expected words per destination.
    logic [WIDTH-1:0] q [4][$];
    logic             pend_v = 1'b0;
    logic [1:0]       pend_s = 2'b00;
    logic [WIDTH-1:0] pend_d = '0;
    logic             exp_sticky = 1'b0;
    logic             prev_stall = 1'b0;
    logic [1:0]       prev_sel = 2'b00;
    logic             mon_en = 1'b0;

    demux64x1_4_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .in_select       (in_select),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data_0      (out_data_0),
        .out_data_1      (out_data_1),
        .out_data_2      (out_data_2),
        .out_data_3      (out_data_3),
        .occupancy       (occupancy),
        .overflow_sticky (overflow_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] dut_head(input int i);
        case (i)
            0: return out_data_0;
            1: return out_data_1;
            2: return out_data_2;
            default: return out_data_3;
        endcase
    endfunction

    // Monitor: state seen at negedge is the state after the last posedge.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 4; i++) begin
                logic [WIDTH-1:0] exp_head;
                exp_head = (q[i].size() != 0) ? q[i][0] : '0;
                check($sformatf("valid_ch%0d", i), 64'(out_valid[i]), 64'(q[i].size() != 0));
                check($sformatf("data_ch%0d", i), dut_head(i), exp_head);
                check($sformatf("occ_ch%0d", i), 64'(occupancy[i*CNT_W +: CNT_W]), 64'(q[i].size()));
                if (q[i].size() != 0 && out_ready[i]) void'(q[i].pop_front());
            end
        end
    end

    // One clock of stimulus; acc reports whether the model expects acceptance.
    task automatic cycle(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                         input logic [3:0] ordy, output logic acc);
        logic exp_ready;
        @(posedge clk);
        #1;
        if (pend_v) begin
            q[pend_s].push_back(pend_d);
            pend_v = 1'b0;
        end
        in_valid  = v;
        in_select = s;
        in_data   = d;
        out_ready = ordy;
        #1;
        exp_ready = (q[s].size() < DEPTH);
        check("sticky", 64'(overflow_sticky), 64'(exp_sticky));
        if (v) check("in_ready", 64'(in_ready), 64'(exp_ready));
        acc = v && exp_ready;
        if (acc) begin
            pend_v = 1'b1;
            pend_s = s;
            pend_d = d;
        end
        if (prev_stall && v && (s != prev_sel)) exp_sticky = 1'b1;
        prev_stall = v && !exp_ready;
        prev_sel   = s;
    endtask

    task automatic idle(input logic [3:0] ordy, input int n);
        logic acc;
        for (int k = 0; k < n; k++) cycle(1'b0, 2'b00, '0, ordy, acc);
    endtask

    task automatic push_word(input logic [1:0] s, input logic [WIDTH-1:0] d, input logic [3:0] ordy);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 20 && !acc; k++) cycle(1'b1, s, d, ordy, acc);
        if (!acc) begin
            tests_run++;
            tests_failed++;
            $display("FAIL push_timeout: sel %0d never accepted", s);
        end
    endtask

    initial begin
        logic acc;
        logic v;
        logic [1:0] s;
        logic [WIDTH-1:0] d;
        logic [3:0] ordy;

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_occupancy", 64'(occupancy), 64'h0);
        check("rst_sticky", 64'(overflow_sticky), 64'h0);
        check("rst_out_data_0", out_data_0, 64'h0);
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'h1);
        mon_en = 1'b1;

        // Basic push/pop on channel 0
        cycle(1'b1, 2'd0, 64'h5555555555555555, 4'b0000, acc);
        idle(4'b0000, 1);
        idle(4'b0001, 1);
        idle(4'b0000, 1);

        // Routing to channels 1..3
        cycle(1'b1, 2'd1, 64'h3333333333333333, 4'b0000, acc);
        cycle(1'b1, 2'd2, 64'h0F0F0F0F0F0F0F0F, 4'b0000, acc);
        cycle(1'b1, 2'd3, 64'h00FF00FF00FF00FF, 4'b0000, acc);
        idle(4'b0000, 2);
        idle(4'b0110, 1);

        // Full and backpressure on channel 2, no pop-bypass
        cycle(1'b1, 2'd2, 64'h1, 4'b0000, acc);
        cycle(1'b1, 2'd2, 64'h2, 4'b0000, acc);
        cycle(1'b1, 2'd2, 64'h3, 4'b0000, acc);
        cycle(1'b1, 2'd2, 64'h3, 4'b0100, acc);
        cycle(1'b1, 2'd2, 64'h3, 4'b0000, acc);
        idle(4'b0000, 1);
        idle(4'b0100, 4);

        // Simultaneous push and pop on channel 3 at occupancy 1
        cycle(1'b1, 2'd3, 64'hA, 4'b1000, acc);
        idle(4'b0000, 2);
        idle(4'b1000, 2);

        // Pointer wrap: stream through channel 0
        for (int k = 1; k <= 10; k++) push_word(2'd0, 64'(k), 4'b0001);
        idle(4'b0001, 3);

        // Fill channel 1, stall, then change select while stalled
        acc = 1'b1;
        for (int k = 0; k < 4 && acc; k++) cycle(1'b1, 2'd1, 64'hC0DE0000 + 64'(k), 4'b0000, acc);
        cycle(1'b1, 2'd0, 64'hBEEF, 4'b0000, acc);
        idle(4'b0000, 1);
        check("sticky_set", 64'(overflow_sticky), 64'h1);

        // Asynchronous reset pulse between clock edges
        @(posedge clk);
        #3;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_occupancy", 64'(occupancy), 64'h0);
        check("midrst_out_valid", 64'(out_valid), 64'h0);
        check("midrst_sticky", 64'(overflow_sticky), 64'h0);
        for (int i = 0; i < 4; i++) q[i].delete();
        pend_v     = 1'b0;
        exp_sticky = 1'b0;
        prev_stall = 1'b0;
        reset_n    = 1'b1;

        // Randomized traffic, producer holds its offer while stalled
        v = 1'b0;
        s = 2'b00;
        d = '0;
        acc = 1'b1;
        for (int n = 0; n < 400; n++) begin
            if (!(v && !acc)) begin
                v = ($urandom_range(0, 3) != 0);
                s = 2'($urandom);
                d = {$urandom, $urandom};
            end
            ordy = 4'($urandom);
            cycle(v, s, d, ordy, acc);
        end

        idle(4'b1111, 8);
        check("drain_occupancy", 64'(occupancy), 64'h0);
        check("drain_out_valid", 64'(out_valid), 64'h0);
        check("final_sticky", 64'(overflow_sticky), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
